// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared command codes, FSM states and ASCII constants for uart_cmd_sender
package uart_cmd_pkg;
  typedef enum logic [1:0] {CMD_WADR, CMD_WDATA, CMD_GO, CMD_QUIT} cmd_t;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_SP, S_HEX, S_CR, S_LF} state_t;
  localparam logic [7:0] ASC_W  = 8'h77;
  localparam logic [7:0] ASC_G  = 8'h67;
  localparam logic [7:0] ASC_Q  = 8'h71;
  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_CR = 8'h0d;
  localparam logic [7:0] ASC_LF = 8'h0a;
endpackage

// File: rtl/uart_cmd_sender_nib2ascii.sv
// nib2ascii: combinational 4-bit nibble to ASCII hex digit
module nib2ascii #(
  parameter bit HEX_UPPER = 1'b0
) (
  input  logic [3:0] nib,
  output logic [7:0] ch
);
  always_comb begin
    ch = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : (HEX_UPPER ? 8'h37 : 8'h57) + {4'h0, nib};
  end
endmodule

// File: rtl/uart_cmd_sender.sv
// uart_cmd_sender: formats monitor command lines as ASCII and streams them into a char/we/full byte path
module uart_cmd_sender
  import uart_cmd_pkg::*;
#(
  parameter bit CRLF      = 1'b1,
  parameter bit HEX_UPPER = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_type,
  input  logic [31:0] cmd_arg,
  output logic        cmd_ready,
  output logic [7:0]  tx_char,
  output logic        tx_we,
  input  logic        tx_full,
  output logic        busy
);
  localparam state_t TERM_S = CRLF ? S_CR : S_LF;
  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  cmd_t        typ;
  logic [31:0] arg;
  logic [7:0]  hex_ch;
  nib2ascii #(.HEX_UPPER(HEX_UPPER)) u_nib (
    .nib(arg[{cnt, 2'b00} +: 4]),
    .ch (hex_ch)
  );
  assign busy      = state != S_IDLE;
  assign cmd_ready = !busy;
  assign tx_we     = busy && !tx_full;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 3'd7;
      typ   <= CMD_WADR;
      arg   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (cmd_valid && cmd_ready) begin
        typ <= cmd_t'(cmd_type);
        arg <= cmd_arg;
      end
    end
  end
  // the 3-bit counter wraps 0 -> 7 on the last digit, so it is ready for the next line
  always_comb begin
    cnt_n   = (state == S_HEX && tx_we) ? cnt - 3'd1 : cnt;
    state_n = (state == S_IDLE) ? (cmd_valid ? (cmd_t'(cmd_type) == CMD_WDATA ? S_HEX : S_CMD) : S_IDLE)
            : !tx_we            ? state
            : (state == S_CMD)  ? (typ == CMD_QUIT ? TERM_S : S_SP)
            : (state == S_SP)   ? S_HEX
            : (state == S_HEX)  ? (cnt == 3'd0 ? TERM_S : S_HEX)
            : (state == S_CR)   ? S_LF
            : S_IDLE;
    tx_char = (state == S_CMD) ? (typ == CMD_WADR ? ASC_W : typ == CMD_GO ? ASC_G : ASC_Q)
            : (state == S_SP)  ? ASC_SP
            : (state == S_HEX) ? hex_ch
            : (state == S_CR)  ? ASC_CR
            : ASC_LF;
  end
endmodule

// File: tb/tb_uart_cmd_sender.sv
// tb_uart_cmd_sender: three parameter variants share stimulus; byte streams checked against a string-level line model
module tb_uart_cmd_sender;
  import uart_cmd_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
  logic        full_dir = 1'b0, full_rnd = 1'b0, rand_en = 1'b0;
  logic [1:0]  cmd_type = 2'd0;
  logic [31:0] cmd_arg = '0;
  logic        tx_full;
  logic [7:0]  tx_char [3];
  logic        tx_we [3], busy [3], cmd_ready [3];
  logic [7:0]  cap [3][$];
  int          acyc [$];
  int          base [3];
  string       exp_s [3];
  int          cyc = 0, tests = 0, fails = 0;
  int          t1, t2, r;

  assign tx_full = full_dir | (rand_en & full_rnd);
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gi
    uart_cmd_sender #(.CRLF(g == 0), .HEX_UPPER(g == 1)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_arg(cmd_arg),
      .cmd_ready(cmd_ready[g]), .tx_char(tx_char[g]), .tx_we(tx_we[g]), .tx_full(tx_full), .busy(busy[g])
    );
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) if (tx_we[k]) cap[k].push_back(tx_char[k]);
    if (tx_we[0]) acyc.push_back(cyc);
  end

  initial forever begin
    @(posedge clk);
    #1 full_rnd = ($urandom_range(0, 3) == 0);
  end

  function automatic string line(input int t, input logic [31:0] a, input bit crlf, input bit up);
    string h, term;
    h = $sformatf("%08x", a);
    if (up) h = h.toupper();
    term = crlf ? "\015\012" : "\012";
    case (t)
      0:       return {"w ", h, term};
      1:       return {h, term};
      2:       return {"g ", h, term};
      default: return {"q", term};
    endcase
  endfunction

  function automatic string to_hex(input string s);
    string o = "";
    for (int i = 0; i < s.len(); i++) o = {o, $sformatf("%02x", s[i])};
    return o;
  endfunction

  task automatic check(input string tag, input int act, input int exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s got %0d exp %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    if (tx_full) for (int k = 0; k < 3; k++) check($sformatf("we_while_full[%0d]", k), int'(tx_we[k]), 0);
  endtask

  task automatic check_streams(input string tag);
    string act;
    for (int k = 0; k < 3; k++) begin
      act = "";
      for (int i = base[k]; i < cap[k].size(); i++) act = {act, $sformatf("%02x", cap[k][i])};
      tests++;
      assert (act == to_hex(exp_s[k])) else begin
        fails++;
        $error("FAIL %s[%0d] got %s exp %s", tag, k, act, to_hex(exp_s[k]));
      end
      base[k] = cap[k].size();
      exp_s[k] = "";
    end
  endtask

  task automatic wait_all();
    for (int i = 0; i < 300; i++) begin
      tick();
      if (cmd_ready[0] && cmd_ready[1] && cmd_ready[2]) return;
    end
    check("idle_timeout", 0, 1);
  endtask

  task automatic wait_ready_a(output int rc);
    rc = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (cmd_ready[0]) begin
        rc = cyc;
        return;
      end
    end
    check("ready_timeout", 0, 1);
  endtask

  task automatic wait_cap(input int n);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (cap[0].size() - base[0] >= n) return;
    end
    check("cap_timeout", 0, 1);
  endtask

  task automatic request(input int t, input logic [31:0] a);
    cmd_type = 2'(t);
    cmd_arg = a;
    cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) exp_s[k] = {exp_s[k], line(t, a, k == 0, k == 1)};
  endtask

  // returns the cycle in which instance 0 sampled the request; cmd_valid is left as is
  task automatic accept_a(output int ta);
    ta = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (cmd_ready[0] && cmd_valid) begin
        ta = cyc;
        @(posedge clk);
        #1;
        return;
      end
    end
    check("accept_timeout", 0, 1);
  endtask

  task automatic send(input int t, input logic [31:0] a, output int ta);
    wait_all();
    @(posedge clk);
    #1 request(t, a);
    accept_a(ta);
    cmd_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_ready[%0d]", k), int'(cmd_ready[k]), 1);
      check($sformatf("rst_busy[%0d]", k), int'(busy[k]), 0);
      check($sformatf("rst_we[%0d]", k), int'(tx_we[k]), 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    acyc.delete();
    send(0, 32'h0000_1000, t1);
    wait_ready_a(r);
    check("wadr_first_cycle", acyc[0], t1 + 1);
    check("wadr_last_cycle", acyc[acyc.size() - 1], t1 + 12);
    check("wadr_byte_count", acyc.size(), 12);
    check("wadr_ready_cycle", r, t1 + 13);
    wait_all();
    check_streams("wadr");

    send(1, 32'hDEAD_BEEF, t1);
    wait_ready_a(r);
    check("wdata_ready_cycle", r, t1 + 11);
    wait_all();
    check_streams("wdata_deadbeef");

    wait_all();
    @(posedge clk);
    #1 request(3, 32'hFFFF_FFFF);
    accept_a(t1);
    request(2, 32'h0000_0000);
    accept_a(t2);
    cmd_valid = 1'b0;
    check("b2b_accept_cycle", t2, t1 + 4);
    wait_all();
    check_streams("quit_go_b2b");

    send(1, 32'h1234_5678, t1);
    wait_cap(3);
    @(posedge clk);
    #1 full_dir = 1'b1;
    repeat (5) tick();
    @(posedge clk);
    #1 full_dir = 1'b0;
    wait_ready_a(r);
    check("stall_ready_cycle", r, t1 + 16);
    wait_all();
    check_streams("stall");

    send(1, 32'h1111_1111, t1);
    wait_cap(3);
    @(posedge clk);
    #1 request(2, 32'hAAAA_AAAA);
    accept_a(t2);
    cmd_valid = 1'b0;
    check("busy_ignore_accept", t2, t1 + 11);
    wait_all();
    check_streams("busy_ignore");

    send(0, 32'hCAFE_F00D, t1);
    wait_cap(4);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("midrst_we[%0d]", k), int'(tx_we[k]), 0);
      check($sformatf("midrst_ready[%0d]", k), int'(cmd_ready[k]), 1);
      exp_s[k] = exp_s[k].substr(0, 3);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_streams("reset_abandon");
    send(3, 32'h0, t1);
    wait_all();
    check_streams("quit_after_reset");

    rand_en = 1'b1;
    for (int n = 0; n < 25; n++) begin
      send(int'($urandom_range(0, 3)), $urandom, t1);
      wait_all();
      check_streams($sformatf("random_%0d", n));
    end
    rand_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
